multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM-subset core. Decodes the instruction register and sequences the datapath through fetch, decode, execute, memory and writeback steps.
- Holds the NZCV condition-flag register and evaluates condition codes.
- Gates every architectural write (register file, memory, PC) with the condition result.
- Sits directly upstream of the datapath. All datapath control inputs come from this block; it consumes ALUFlags back from the datapath.

Parameters:
- None. The ARM-subset encoding is fixed.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- Instr  in  32  instruction register contents; bits [31:12] are used
- ALUFlags  in  4  ALU flags: [3]=N, [2]=Z, [1]=C, [0]=V
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  ALU source A: 0=RD1, 1=PC
- ALUSrcB  out  2  ALU source B: 00=RD2, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  immediate format: 00=DP imm8, 01=mem imm12, 10=branch imm24
- RegSrc  out  2  register-address select, as the datapath defines it
- RegWrite  out  1  register file write enable
- ALUControl  out  2  ALU operation: 00=add, 01=sub, 10=and, 11=orr
- State  out  4  current FSM state, for debug

Behaviour:
- Decode fields: cond=Instr[31:28], op=Instr[27:26], funct=Instr[25:20], Rd=Instr[15:12].
- Moore FSM. States:
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, add, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, add, ResultSrc=10. Latch CondExReg from the current flags and cond.
  - MEMADR: ALUSrcA=0, ALUSrcB=01. Add if U (funct[3]) = 1, else sub.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALU op from funct[4:1].
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALU op from funct[4:1].
  - ALUWB: ResultSrc=00, RegW=1 unless cmd=CMP (1010).
  - BRANCH: ALUSrcA=0, ALUSrcB=01, add, ResultSrc=10, Branch=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (op=01), EXECUTER (op=00 and I=0), EXECUTEI (op=00 and I=1), BRANCH (op=10), FETCH (op=11, undefined; no writes).
  - MEMADR→MEMREAD if L (funct[0]) = 1, else MEMWRITE.
  - MEMREAD→MEMWB→FETCH; MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI→ALUWB→FETCH; BRANCH→FETCH.
- Latency in cycles, cond true or false: DP 4, LDR 5, STR 4, B 3, undefined 2.
- ALU decode for cmd funct[4:1]:
  - 0100 ADD → 00; 0010 SUB → 01; 1010 CMP → 01; 0000 AND → 10; 1100 ORR → 11.
  - Any other cmd: ALUControl=00 and RegW suppressed.
- ImmSrc = op. RegSrc[0] = (op==10). RegSrc[1] = (op==01).
- Condition codes: all 15 ARM codes (EQ..LE, AL=1110) are evaluated from the flag register. cond=1111 is never-true.
- Output gating, all using CondExReg:
  - RegWrite = RegW & CondExReg.
  - MemWrite = MemW & CondExReg.
  - PCWrite = NextPC | (Branch & CondExReg) | (RegW & CondExReg & Rd==15).
- Flag register:
  - Updates at the rising edge ending EXECUTER/EXECUTEI, only when S (funct[0]) = 1 and CondExReg=1.
  - N, Z: updated for every DP cmd.
  - C, V: updated for ADD/SUB/CMP only.
  - Flags are never written in other states. CondExReg is therefore stable across ALUWB.
- Reset (reset==0 at a rising edge):
  - state←FETCH; flags←0000; CondExReg←0.
  - While reset is low, IRWrite, PCWrite, MemWrite and RegWrite are forced 0. All other outputs take FETCH values.
  - Reset mid-instruction abandons the instruction with no further writes.
  - First fetch occurs in the first cycle after reset returns high.

Test Plan:
- Reset held 3 cycles with Instr=E2821005, then released → no write enables while low. Trace: FETCH(IRWrite=1, PCWrite=1), DECODE, EXECUTEI(ALUSrcB=01, ALUControl=00), ALUWB(RegWrite=1, ResultSrc=00), FETCH. Total 4 cycles.
- SUBS E0513001 with ALUFlags=0100 during EXECUTER → flags=0100. A following 0A000002 (BEQ) reaches BRANCH with PCWrite=1.
- Same BEQ with flags=0000 → BRANCH asserts PCWrite=0; next state is FETCH.
- LDR E5904008 → MEMADR(add), MEMREAD(AdrSrc=1), MEMWB(ResultSrc=01, RegWrite=1): 5 cycles. STR E580400C → MEMWRITE asserts MemWrite=1 for exactly 1 cycle.
- ADD PC E28FF000 → ALUWB asserts both RegWrite=1 and PCWrite=1. CMP (cmd 1010, S=1) → ALUWB with RegWrite=0; flags updated.
- Reset driven low during MEMADR of an STR → MemWrite never asserts. State reads FETCH on the next edge; flags=0000.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: instruction decode, Moore sequencing FSM,
// NZCV flag register and condition-gated architectural write enables.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ALUControl,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBranch
  } state_e;

  state_e     state_q, state_d, cur_state;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       unused_instr;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign cmd   = funct[4:1];
  assign unused_instr = ^Instr[11:0];

  // While reset is low the outputs behave as FETCH regardless of the stored state.
  assign cur_state = reset ? state_q : StFetch;
  assign State     = cur_state;

  // Data-processing command decode
  logic [1:0] alu_dp;
  logic       cmd_valid;
  logic       cmd_arith;
  logic       cmd_cmp;

  always_comb begin
    alu_dp    = 2'b00;
    cmd_valid = 1'b1;
    cmd_arith = 1'b0;
    cmd_cmp   = 1'b0;
    case (cmd)
      4'b0100: begin alu_dp = 2'b00; cmd_arith = 1'b1; end
      4'b0010: begin alu_dp = 2'b01; cmd_arith = 1'b1; end
      4'b1010: begin alu_dp = 2'b01; cmd_arith = 1'b1; cmd_cmp = 1'b1; end
      4'b0000: alu_dp = 2'b10;
      4'b1100: alu_dp = 2'b11;
      default: cmd_valid = 1'b0;
    endcase
  end

  // Condition evaluation against the flag register
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_met;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_met = 1'b0;
    case (cond)
      4'b0000: cond_met = flag_z;
      4'b0001: cond_met = ~flag_z;
      4'b0010: cond_met = flag_c;
      4'b0011: cond_met = ~flag_c;
      4'b0100: cond_met = flag_n;
      4'b0101: cond_met = ~flag_n;
      4'b0110: cond_met = flag_v;
      4'b0111: cond_met = ~flag_v;
      4'b1000: cond_met = flag_c & ~flag_z;
      4'b1001: cond_met = ~flag_c | flag_z;
      4'b1010: cond_met = (flag_n == flag_v);
      4'b1011: cond_met = (flag_n != flag_v);
      4'b1100: cond_met = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_met = flag_z | (flag_n != flag_v);
      4'b1110: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = StFetch;
    unique case (cur_state)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          2'b00:   state_d = funct[5] ? StExecuteI : StExecuteR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = funct[0] ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  // Condition latch and flag register next state
  logic in_execute;

  assign in_execute = (cur_state == StExecuteR) || (cur_state == StExecuteI);

  always_comb begin
    condex_d = condex_q;
    flags_d  = flags_q;
    if (cur_state == StDecode) begin
      condex_d = cond_met;
    end
    if (in_execute && funct[0] && condex_q) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (cmd_arith) begin
        flags_d[1:0] = ALUFlags[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StFetch;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  // Moore outputs, ungated write intents first
  logic irw, nextpc, regw, memw, branch;

  always_comb begin
    irw        = 1'b0;
    nextpc     = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    branch     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    unique case (cur_state)
      StFetch: begin
        irw       = 1'b1;
        nextpc    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StMemAdr: begin
        ALUSrcB    = 2'b01;
        ALUControl = funct[3] ? 2'b00 : 2'b01;
      end
      StMemRead: AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        regw      = 1'b1;
      end
      StMemWrite: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
      end
      StExecuteR: ALUControl = alu_dp;
      StExecuteI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_dp;
      end
      StAluWb: regw = cmd_valid & ~cmd_cmp;
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};

  // Writes are suppressed outright while reset is asserted.
  assign IRWrite  = irw & reset;
  assign RegWrite = regw & condex_q & reset;
  assign MemWrite = memw & condex_q & reset;
  assign PCWrite  = (nextpc | (branch & condex_q) | (regw & condex_q & (rd == 4'hF))) & reset;

endmodule
